// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding and the
// field values the MEM/WB register takes when it is loaded with a bubble.
package mem_stage_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;

  localparam logic        BUBBLE_REG_WRITE  = 1'b0;
  localparam logic        BUBBLE_MEM_TO_REG = 1'b0;
  localparam logic [31:0] BUBBLE_READ_DATA  = 32'h0;
  localparam logic [31:0] BUBBLE_ALU_RESULT = 32'h0;
  localparam logic [4:0]  BUBBLE_RD_ADDR    = 5'h0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble load writes the nop encoding so that a
// stalled or aborted memory access never reaches writeback.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bubble,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  input  logic [31:0] i_read_data,
  input  logic [31:0] i_alu_result,
  input  logic [4:0]  i_rd_addr,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic [31:0] o_read_data,
  output logic [31:0] o_alu_result,
  output logic [4:0]  o_rd_addr
);

  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_rd_addr;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_rd_addr    <= '0;
    end else if (i_bubble) begin
      r_reg_write  <= BUBBLE_REG_WRITE;
      r_mem_to_reg <= BUBBLE_MEM_TO_REG;
      r_read_data  <= BUBBLE_READ_DATA;
      r_alu_result <= BUBBLE_ALU_RESULT;
      r_rd_addr    <= BUBBLE_RD_ADDR;
    end else begin
      r_reg_write  <= i_reg_write;
      r_mem_to_reg <= i_mem_to_reg;
      r_read_data  <= i_read_data;
      r_alu_result <= i_alu_result;
      r_rd_addr    <= i_rd_addr;
    end
  end

  assign o_reg_write  = r_reg_write;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_read_data  = r_read_data;
  assign o_alu_result = r_alu_result;
  assign o_rd_addr    = r_rd_addr;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: req/ack data-memory access with stall and timeout abort,
// branch resolution, and the MEM/WB register. Option: MEM_ACCESS_STAGE_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ALUResult_i,
  input  logic [31:0]       RS2data_i,
  input  logic              Zero_i,
  input  logic [31:0]       pc_branch_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic [4:0]        RDaddr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              stall_o,
  output logic              PCSrc_o,
  output logic [31:0]       pc_branch_o,
  output logic              err_o,
`ifdef MEM_ACCESS_STAGE_MISALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [31:0]       ReadData_o,
  output logic [31:0]       ALUResult_o,
  output logic [4:0]        RDaddr_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic             r_state;
  logic             w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_access;
  logic             w_req_active;
  logic             w_abort;
  logic             w_stall;
  logic             w_bubble;
  logic [31:0]      w_read_data;

  assign w_access = MemRead_i | MemWrite_i;

`ifdef MEM_ACCESS_STAGE_MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign;

  // A misaligned access never reaches memory; it is squashed into a bubble.
  assign w_misalign   = w_access & (|ALUResult_i[1:0]);
  assign w_req_active = w_access & ~w_misalign;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          r_misalign <= 1'b0;
    else if (w_misalign) r_misalign <= 1'b1;
  end

  assign misalign_o = r_misalign;
  assign w_bubble   = w_stall | w_abort | w_misalign;
`else
  assign w_req_active = w_access;
  assign w_bubble     = w_stall | w_abort;
`endif

  // The counter value equals the number of request cycles already spent, so
  // the abort fires on the MEM_TIMEOUT-th cycle without an ack.
  assign w_abort = (MEM_TIMEOUT != 0) && w_req_active && !mem_ack_i &&
                   (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_stall = w_req_active & ~mem_ack_i & ~w_abort;

  assign mem_req_o   = rst_i & w_req_active & ~w_abort;
  assign mem_we_o    = MemWrite_i;
  assign mem_addr_o  = ALUResult_i[ADDR_W-1:0];
  assign mem_wdata_o = RS2data_i;
  assign stall_o     = w_stall;
  assign err_o       = r_err;

  assign PCSrc_o     = Branch_i & Zero_i & ~w_stall;
  assign pc_branch_o = pc_branch_i;

  // Only a completing read returns data; writes and ALU ops load zero.
  assign w_read_data = (MemRead_i & ~MemWrite_i & w_req_active & mem_ack_i) ? mem_rdata_i : 32'h0;

  // NOTE: assigning a default before the case keeps this block free of latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_IDLE: if (w_stall)  w_state_next = STATE_BUSY;
      STATE_BUSY: if (!w_stall) w_state_next = STATE_IDLE;
      default:                  w_state_next = STATE_IDLE;
    endcase
  end

  // NOTE: every control register is cleared by the asynchronous reset; only the
  // MEM/WB datapath fields carry no meaning until loaded, yet they are cleared too.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= STATE_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == STATE_BUSY) begin
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .i_clk        (clk_i),
    .i_rst_n      (rst_i),
    .i_bubble     (w_bubble),
    .i_reg_write  (RegWrite_i),
    .i_mem_to_reg (MemtoReg_i),
    .i_read_data  (w_read_data),
    .i_alu_result (ALUResult_i),
    .i_rd_addr    (RDaddr_i),
    .o_reg_write  (RegWrite_o),
    .o_mem_to_reg (MemtoReg_o),
    .o_read_data  (ReadData_o),
    .o_alu_result (ALUResult_o),
    .o_rd_addr    (RDaddr_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage, built with MEM_TIMEOUT=4.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ALUResult_i;
  logic [31:0] RS2data_i;
  logic        Zero_i;
  logic [31:0] pc_branch_i;
  logic        Branch_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        MemtoReg_i;
  logic        RegWrite_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        PCSrc_o;
  logic [31:0] pc_branch_o;
  logic        err_o;
`ifdef MEM_ACCESS_STAGE_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] ReadData_o;
  logic [31:0] ALUResult_o;
  logic [4:0]  RDaddr_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.MEM_TIMEOUT(4), .ADDR_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ALUResult_i (ALUResult_i),
    .RS2data_i   (RS2data_i),
    .Zero_i      (Zero_i),
    .pc_branch_i (pc_branch_i),
    .Branch_i    (Branch_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .RegWrite_i  (RegWrite_i),
    .RDaddr_i    (RDaddr_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .PCSrc_o     (PCSrc_o),
    .pc_branch_o (pc_branch_o),
    .err_o       (err_o),
`ifdef MEM_ACCESS_STAGE_MISALIGN_CHECK_EN
    .misalign_o  (misalign_o),
`endif
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .ReadData_o  (ReadData_o),
    .ALUResult_o (ALUResult_o),
    .RDaddr_o    (RDaddr_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    ALUResult_i = '0; RS2data_i = '0; Zero_i = 1'b0; pc_branch_i = '0;
    Branch_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 1'b0;
    RegWrite_i = 1'b0; RDaddr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  initial begin
    rst_i = 1'b0;
    idle_inputs();

    // Reset state
    #3;
    check("rst_req",      mem_req_o,   0);
    check("rst_err",      err_o,       0);
    check("rst_regwrite", RegWrite_o,  0);
    check("rst_alures",   ALUResult_o, 0);
    #9 rst_i = 1'b1;
    tick();

    // ALU op passes through in one cycle
    RegWrite_i = 1'b1; RDaddr_i = 5'd5; ALUResult_i = 32'h0000_0010;
    #1;
    check("alu_stall", stall_o,   0);
    check("alu_req",   mem_req_o, 0);
    tick();
    check("alu_rd",       RDaddr_o,    5);
    check("alu_result",   ALUResult_o, 32'h10);
    check("alu_regwrite", RegWrite_o,  1);
    check("alu_readdata", ReadData_o,  0);

    // Load at 0x100, ack on the fourth cycle
    idle_inputs();
    MemRead_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd7;
    ALUResult_i = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_stall", stall_o,    1);
      check("ld_req",   mem_req_o,  1);
      check("ld_we",    mem_we_o,   0);
      check("ld_addr",  mem_addr_o, 32'h100);
      tick();
      check("ld_bubble_rw", RegWrite_o, 0);
      check("ld_bubble_rd", RDaddr_o,   0);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("ld_ack_stall", stall_o,   0);
    check("ld_ack_req",   mem_req_o, 1);
    tick();
    check("ld_readdata", ReadData_o, 32'hDEAD_BEEF);
    check("ld_memtoreg", MemtoReg_o, 1);
    check("ld_regwrite", RegWrite_o, 1);
    check("ld_rd",       RDaddr_o,   7);
    check("ld_err",      err_o,      0);

    // Store with same-cycle ack
    idle_inputs();
    MemWrite_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd2;
    ALUResult_i = 32'h0000_0200; RS2data_i = 32'h0000_1234;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    check("st_we",    mem_we_o,    1);
    check("st_wdata", mem_wdata_o, 32'h1234);
    check("st_addr",  mem_addr_o,  32'h200);
    check("st_stall", stall_o,     0);
    check("st_req",   mem_req_o,   1);
    tick();
    check("st_regwrite", RegWrite_o,  1);
    check("st_readdata", ReadData_o,  0);
    check("st_alures",   ALUResult_o, 32'h200);

    // Load without ack: aborted on the fourth cycle
    idle_inputs();
    MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd9; ALUResult_i = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_stall", stall_o,   1);
      check("to_req",   mem_req_o, 1);
      tick();
    end
    #1;
    check("to_abort_stall", stall_o,   0);
    check("to_abort_req",   mem_req_o, 0);
    check("to_abort_err0",  err_o,     0);
    tick();
    check("to_err",        err_o,       1);
    check("to_bubble_rw",  RegWrite_o,  0);
    check("to_bubble_alu", ALUResult_o, 0);

    // Ack outside a request is ignored; err stays sticky
    idle_inputs();
    RegWrite_i = 1'b1; RDaddr_i = 5'd3; ALUResult_i = 32'h0000_0055;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("ign_req",   mem_req_o, 0);
    check("ign_stall", stall_o,   0);
    tick();
    check("ign_readdata", ReadData_o,  0);
    check("ign_alures",   ALUResult_o, 32'h55);
    check("ign_err",      err_o,       1);

    // Branch resolution
    idle_inputs();
    Branch_i = 1'b1; Zero_i = 1'b1; pc_branch_i = 32'h0000_0040;
    #1;
    check("br_taken", PCSrc_o,     1);
    check("br_pc",    pc_branch_o, 32'h40);
    Zero_i = 1'b0;
    #1;
    check("br_not_taken", PCSrc_o, 0);
    tick();

    // Branch suppressed while stalled, then reset during BUSY
    idle_inputs();
    MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd4; ALUResult_i = 32'h0000_0400;
    Branch_i = 1'b1; Zero_i = 1'b1; pc_branch_i = 32'h0000_0080;
    #1;
    check("brst_pcsrc", PCSrc_o, 0);
    check("brst_stall", stall_o, 1);
    tick();
    #1 rst_i = 1'b0;
    #1;
    check("rb_req",      mem_req_o,  0);
    check("rb_err",      err_o,      0);
    check("rb_regwrite", RegWrite_o, 0);
    check("rb_rd",       RDaddr_o,   0);
    idle_inputs();
    RegWrite_i = 1'b1; RDaddr_i = 5'd11; ALUResult_i = 32'h0000_0077;
    #3 rst_i = 1'b1;
    #1;
    check("rec_stall", stall_o, 0);
    tick();
    check("rec_rd",       RDaddr_o,   11);
    check("rec_regwrite", RegWrite_o, 1);

`ifdef MEM_ACCESS_STAGE_MISALIGN_CHECK_EN
    // Misaligned load is squashed
    idle_inputs();
    MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd6; ALUResult_i = 32'h0000_0102;
    #1;
    check("mis_req",   mem_req_o,  0);
    check("mis_stall", stall_o,    0);
    check("mis_flag0", misalign_o, 0);
    tick();
    check("mis_bubble", RegWrite_o, 0);
    check("mis_flag",   misalign_o, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage directly downstream of the EX/MEM register; consumes its ALU result, store data, branch info and control bits.
- Drives a req/ack data-memory interface that may take multiple cycles, and stalls the upstream pipeline while an access is outstanding.
- Resolves branch-taken (PCSrc), and contains the MEM/WB pipeline register feeding writeback.

Parameters:
- MEM_TIMEOUT, 64, max cycles in BUSY without ack before abort; 0 disables timeout.
- ADDR_W, 32, memory address width (low ADDR_W bits of ALUResult_i).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- ALUResult_i  in  32  address (load/store) or result (ALU op)
- RS2data_i  in  32  store data
- Zero_i  in  1  ALU zero flag
- pc_branch_i  in  32  branch target
- Branch_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i  in  1 each  control from EX/MEM
- RDaddr_i  in  5  destination register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  write data
- mem_ack_i  in  1  memory completion (one-cycle pulse)
- mem_rdata_i  in  32  read data, valid with ack
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- PCSrc_o  out  1  branch taken
- pc_branch_o  out  32  pass-through of pc_branch_i
- err_o  out  1  sticky timeout error
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control
- ReadData_o, ALUResult_o  out  32 each  MEM/WB data
- RDaddr_o  out  5  MEM/WB destination

Behaviour:
- rst_i low (async): state=IDLE, timeout counter=0, err_o=0, all MEM/WB outputs 0; mem_req_o forced 0 while rst_i low.
- access = MemRead_i | MemWrite_i; MemRead_i & MemWrite_i both high is treated as a write.
- States IDLE, BUSY.
  - IDLE, access=1: mem_req_o=1 combinationally. If mem_ack_i=1 the same cycle, the access completes (zero-wait); else go to BUSY.
  - BUSY: mem_req_o=1. On mem_ack_i=1, complete and return to IDLE.
- mem_addr_o/mem_we_o/mem_wdata_o come straight from the inputs; they stay stable because upstream is stalled.
- stall_o = access & !mem_ack_i & !abort (combinational).
- Completion edge: MEM/WB loads the inputs; ReadData_o=mem_rdata_i for reads and 0 for writes.
- Non-access cycle: MEM/WB loads inputs every edge, ReadData_o=0.
- While stall_o=1, MEM/WB loads a bubble: RegWrite_o=0, MemtoReg_o=0, other fields 0.
- Timeout counter:
  - Counts cycles in BUSY; reset on entry to IDLE; saturating width clog2(MEM_TIMEOUT+1).
  - abort = (MEM_TIMEOUT!=0) & (cnt==MEM_TIMEOUT-1) & !mem_ack_i.
  - On abort: drop request, set err_o, stall released, MEM/WB loads bubble, state→IDLE.
  - err_o clears only on reset.
- mem_ack_i outside a request is ignored.
- PCSrc_o = Branch_i & Zero_i & !stall_o; pc_branch_o = pc_branch_i (combinational).
- Latency: non-memory op 1 cycle; memory op 1 + N wait cycles.

Optional Feature:
- Macro MEM_ACCESS_STAGE_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, sticky, reset 0).
  - An access with ALUResult_i[1:0]!=0 issues no mem_req_o and no stall.
  - MEM/WB loads a bubble and misalign_o sets.
- When undefined: no port; address is passed unchanged.

Decomposition:
- Shared package (mem_stage_pkg): state encoding (IDLE=1'b0, BUSY=1'b1) and MEM/WB bubble constants.
- One sub-module: mem_wb_reg (MEM/WB register with bubble-load input and async active-low reset).
- FSM, timeout counter and branch logic stay in the top module.

Test Plan:
- ALU op with RegWrite_i=1, RDaddr_i=5, ALUResult_i=0x0000_0010 → next edge RDaddr_o=5, ALUResult_o=0x10, RegWrite_o=1, stall_o never high.
- Load at 0x100, ack after 3 cycles with rdata=0xDEADBEEF → stall_o high 3 cycles with bubbles in MEM/WB; then ReadData_o=0xDEADBEEF, MemtoReg_o=1.
- Store of 0x1234 to 0x200 with same-cycle ack → mem_we_o=1, mem_wdata_o=0x1234, stall_o=0, RegWrite_o follows input.
- Load with no ack, MEM_TIMEOUT=4 → req dropped after 4 cycles, err_o=1, stall released, bubble loaded.
- Branch_i=1, Zero_i=1, pc_branch_i=0x40 → PCSrc_o=1, pc_branch_o=0x40; with Zero_i=0 → PCSrc_o=0.
- rst_i low during BUSY → mem_req_o=0 immediately, state IDLE, outputs 0, err_o=0.
